adding_cpu_gen: RTL and testbench
=================================

Name: adding_cpu_gen

Overview:
Parametrised successor to the 2-bit-opcode adding CPU. It has the same shared-memory bus style: address, read/write strobes and a bidirectional data bus. It widens the opcode to 3 bits with a carry flag, conditional jumps and halt. It adds run and single-step modes, edge-detected step, clock-enable freeze and a retired-instruction counter.

Parameters:
DATA_W, 8, data/instruction word width; must satisfy DATA_W >= ADDR_W+3.
ADDR_W, 5, memory address width; PC and operand width.
CNT_W, 16, retired-instruction counter width.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk_in  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
en  input  1  global clock enable; 0 freezes all state.
mode  input  1  0 = single-step, 1 = free run.
step  input  1  start request; rising edge detected internally.
adr_bus  output  ADDR_W  memory address.
rd_mem  output  1  memory read strobe; memory drives data_bus combinationally.
wr_mem  output  1  memory write strobe; memory captures on the posedge ending the cycle.
data_bus  inout  DATA_W  driven with AC only while wr_mem=1, else high-Z.
idle  output  1  1 in IDLE or HALTED.
halted  output  1  1 in HALTED.
pc_out  output  ADDR_W  program counter (debug).
ac_out  output  DATA_W  accumulator (debug).
carry_out  output  1  carry flag (debug).
instr_cnt  output  CNT_W  retired instructions, saturating.

Behaviour:
- Instruction format: opcode = IR[DATA_W-1 -: 3]; operand = IR[ADDR_W-1:0]; bits in between are ignored.
- Opcodes:
  - 000 ADD: AC <= AC+M; carry = bit DATA_W of the sum.
  - 001 AND: AC <= AC&M; carry unchanged.
  - 010 LDA: AC <= M.
  - 011 STA: M <= AC.
  - 100 JMP: PC <= operand.
  - 101 JZ: PC <= operand if AC==0.
  - 110 JC: PC <= operand if carry==1.
  - 111 HLT: go to HALTED.
- Reset (reset_n=0, asynchronous):
  - state=IDLE, PC=RESET_PC, IR=0, AC=0, carry=0, instr_cnt=0, step_q=0.
  - rd_mem=0 and wr_mem=0 immediately; data_bus high-Z.
  - A write in progress is aborted; no memory write occurs.
- en=0: no register or state changes and step_q is held. Outputs remain at their decoded values. rd_mem/wr_mem stay asserted if already asserted; the bench memory must gate writes with en.
- start = step & ~step_q. step_q is registered every enabled cycle.
- FSM states: IDLE, FETCH, DECODE, EXEC_RD, EXEC_WR, HALTED.
- IDLE:
  - adr_bus=PC, strobes 0.
  - Go to FETCH if mode=1, or if mode=0 and start=1.
- FETCH:
  - rd_mem=1, adr_bus=PC.
  - IR <= data_bus; PC <= PC+1 (mod 2^ADDR_W).
  - Go to DECODE.
- DECODE:
  - adr_bus=operand, strobes 0.
  - ADD/AND/LDA go to EXEC_RD; STA goes to EXEC_WR.
  - Jumps update PC conditionally, retire, and go to IDLE.
  - HLT retires and goes to HALTED.
- EXEC_RD:
  - rd_mem=1, adr_bus=operand.
  - AC/carry update at the posedge; retire; go to IDLE.
- EXEC_WR:
  - wr_mem=1, adr_bus=operand, data_bus=AC.
  - Retire; go to IDLE.
- HALTED: terminal. Ignores step and mode; exits only via reset.
- Latency:
  - ADD/AND/LDA/STA take 3 cycles FETCH->EXEC.
  - Jumps and HLT take 2 cycles.
  - Plus 1 IDLE cycle between instructions in every mode.
- Retire: instr_cnt increments once per instruction, including HLT. It saturates at all-ones.
- A step held high executes exactly one instruction. A new rising edge is required for the next.
- A step edge arriving outside IDLE is lost. This is intentional, because step_q tracks every cycle.
- Switching mode mid-instruction takes effect at the next IDLE.
- PC wraps: fetch at 2^ADDR_W-1 leaves PC=0.

Decomposition:
- Shared package adding_cpu_pkg: 3-bit opcode localparams (OP_ADD..OP_HLT) and state encoding localparams.
- Sub-module adding_cpu_gen_cu: FSM, step edge detect and strobe/mux select decode.
- Datapath registers (PC, IR, AC, carry, instr_cnt) stay in the top level.

Test Plan:
- Run mode: mem[0]=0x50, [1]=0x11, [2]=0xC5, [5]=0x72, [6]=0xE0, [0x10]=0x7F, [0x11]=0x90 -> AC=0x0F, carry=1 after ADD. JC is taken, so PC=5. mem[0x12]=0x0F. halted=1, instr_cnt=5, PC=7.
- Step mode, same program, step held high 5 cycles -> exactly one instruction (LDA): AC=0x7F, idle=1, instr_cnt=1. Four further pulses reach halted.
- JZ: mem[0]=0x30 (AND 0x10) with [0x10]=0x00, then [1]=0xA8 -> AC=0, PC=8. With [0x10]=0xFF and preloaded AC=0x01, JZ is not taken and PC=2.
- en=0 for 4 cycles while in EXEC_RD -> PC/AC/state/instr_cnt unchanged. Execution resumes and completes correctly when en returns to 1.
- reset_n low during EXEC_WR of STA 0x12 -> wr_mem drops the same instant, mem[0x12] is unchanged, and PC=RESET_PC, AC=0, instr_cnt=0.
- mem[0x1F]=0x58 (LDA 0x18), reached via JMP 0x1F (0x9F) -> after that fetch PC=0x00, and the next fetch address is 0x00.

Source files
------------

// File: rtl/adding_cpu_pkg.sv
// Shared definitions for the parametrised adding CPU: opcodes, FSM state
// encoding and the control word the control unit hands to the datapath.
package adding_cpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STA = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_JC  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_DECODE  = 3'd2;
  localparam state_t ST_EXEC_RD = 3'd3;
  localparam state_t ST_EXEC_WR = 3'd4;
  localparam state_t ST_HALTED  = 3'd5;

  typedef struct packed {
    logic rd_mem;    // memory read strobe
    logic wr_mem;    // memory write strobe, also enables the data bus driver
    logic adr_opnd;  // address mux: 1 = IR operand, 0 = PC
    logic fetch;     // load IR from the bus and advance PC
    logic exec_rd;   // apply ADD/AND/LDA to AC/carry
    logic jump;      // load PC from the operand
    logic retire;    // instruction completes this cycle
  } ctrl_t;

  // Jumps and HLT all finish in DECODE; they share the top opcode bit.
  function automatic logic retires_in_decode(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/adding_cpu_gen_if.sv
// Memory address/strobe bundle between the CPU (master) and memory (slave).
interface adding_cpu_gen_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] adr_bus;
  logic              rd_mem;
  logic              wr_mem;

  modport master (output adr_bus, output rd_mem, output wr_mem);
  modport slave  (input  adr_bus, input  rd_mem, input  wr_mem);
endinterface

// File: rtl/adding_cpu_gen_cu.sv
// Control unit: step edge detection, instruction FSM and the decode of
// strobes and datapath load enables for each state.
module adding_cpu_gen_cu
  import adding_cpu_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       en,
  input  logic       mode,
  input  logic       step,
  input  logic [2:0] opcode,
  input  logic       ac_zero,
  input  logic       carry,
  output ctrl_t      ctrl,
  output logic       idle,
  output logic       halted
);

  state_t state;
  state_t state_nx;
  logic   step_q;
  logic   start;

  // step_q follows step on every enabled cycle, so an edge seen outside IDLE
  // is consumed and never replayed later.
  assign start = step & ~step_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      step_q <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state  <= state_nx;
      step_q <= step;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_nx = state;
    case (state)
      ST_IDLE:    if (mode || start) state_nx = ST_FETCH;
      ST_FETCH:   state_nx = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_LDA: state_nx = ST_EXEC_RD;
          OP_STA:                 state_nx = ST_EXEC_WR;
          OP_HLT:                 state_nx = ST_HALTED;
          default:                state_nx = ST_IDLE;
        endcase
      end
      ST_EXEC_RD: state_nx = ST_IDLE;
      ST_EXEC_WR: state_nx = ST_IDLE;
      ST_HALTED:  state_nx = ST_HALTED;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.rd_mem = 1'b1;
        ctrl.fetch  = 1'b1;
      end
      ST_DECODE: begin
        ctrl.adr_opnd = 1'b1;
        ctrl.retire   = retires_in_decode(opcode);
        ctrl.jump     = (opcode == OP_JMP)
                      || ((opcode == OP_JZ) && ac_zero)
                      || ((opcode == OP_JC) && carry);
      end
      ST_EXEC_RD: begin
        ctrl.rd_mem   = 1'b1;
        ctrl.adr_opnd = 1'b1;
        ctrl.exec_rd  = 1'b1;
        ctrl.retire   = 1'b1;
      end
      ST_EXEC_WR: begin
        ctrl.wr_mem   = 1'b1;
        ctrl.adr_opnd = 1'b1;
        ctrl.retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign idle   = (state == ST_IDLE) || (state == ST_HALTED);
  assign halted = (state == ST_HALTED);

endmodule

// File: rtl/adding_cpu_gen.sv
// Parametrised adding CPU: datapath registers (PC, IR, AC, carry, retired
// count) plus the shared-memory bus; sequencing lives in adding_cpu_gen_cu.
module adding_cpu_gen
  import adding_cpu_pkg::*;
#(
  parameter int DATA_W   = 8,   // must be >= ADDR_W + 3
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 16,
  parameter int RESET_PC = 0
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 step,
  adding_cpu_gen_if.master     bus,
  inout  wire  [DATA_W-1:0]    data_bus,
  output logic                 idle,
  output logic                 halted,
  output logic [ADDR_W-1:0]    pc_out,
  output logic [DATA_W-1:0]    ac_out,
  output logic                 carry_out,
  output logic [CNT_W-1:0]     instr_cnt
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] ac;
  logic              carry;
  logic [CNT_W-1:0]  cnt;
  ctrl_t             ctrl;

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W:0]   sum;

  assign opcode  = ir[DATA_W-1 -: 3];
  assign operand = ir[ADDR_W-1:0];
  assign sum     = {1'b0, ac} + {1'b0, data_bus};

  adding_cpu_gen_cu u_cu (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .en      (en),
    .mode    (mode),
    .step    (step),
    .opcode  (opcode),
    .ac_zero (ac == '0),
    .carry   (carry),
    .ctrl    (ctrl),
    .idle    (idle),
    .halted  (halted)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= PC_INIT;
      ir    <= '0;
      ac    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (en) begin
      if (ctrl.fetch) begin
        ir <= data_bus;
        pc <= pc + ADDR_W'(1);
      end else if (ctrl.jump) begin
        pc <= operand;
      end

      if (ctrl.exec_rd) begin
        case (opcode)
          OP_ADD: begin
            ac    <= sum[DATA_W-1:0];
            carry <= sum[DATA_W];
          end
          OP_AND:  ac <= ac & data_bus;
          OP_LDA:  ac <= data_bus;
          default: ;
        endcase
      end

      if (ctrl.retire && (cnt != '1)) cnt <= cnt + CNT_W'(1);
    end
  end

  // Strobes are decoded straight from state, so reset drops them at once
  // and an in-flight STA never reaches its write edge.
  assign bus.adr_bus = ctrl.adr_opnd ? operand : pc;
  assign bus.rd_mem  = ctrl.rd_mem;
  assign bus.wr_mem  = ctrl.wr_mem;
  assign data_bus    = ctrl.wr_mem ? ac : 'z;

  assign pc_out    = pc;
  assign ac_out    = ac;
  assign carry_out = carry;
  assign instr_cnt = cnt;

endmodule

// File: tb/tb_adding_cpu_gen.sv
// Bench for adding_cpu_gen: vector table of single-instruction programs,
// directed multi-cycle sequences and random programs against an ISA model.
module tb_adding_cpu_gen;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic clk_in = 1'b0;
  logic reset_n, en, mode, step, load_en;
  wire  [DATA_W-1:0] data_bus;
  logic idle, halted, carry_out;
  logic [ADDR_W-1:0] pc_out;
  logic [DATA_W-1:0] ac_out;
  logic [CNT_W-1:0]  instr_cnt;

  logic [7:0] mem  [32];
  logic [7:0] img  [32];
  logic [7:0] mmem [32];

  logic [4:0] m_pc;
  logic [7:0] m_ac;
  logic       m_c, m_halt;
  int         m_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  adding_cpu_gen_if #(.ADDR_W(ADDR_W)) bus ();

  adding_cpu_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RESET_PC(0)) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .en        (en),
    .mode      (mode),
    .step      (step),
    .bus       (bus),
    .data_bus  (data_bus),
    .idle      (idle),
    .halted    (halted),
    .pc_out    (pc_out),
    .ac_out    (ac_out),
    .carry_out (carry_out),
    .instr_cnt (instr_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Memory: combinational read, write on the clock edge, frozen with en.
  assign data_bus = bus.rd_mem ? mem[bus.adr_bus] : 'z;

  always @(posedge clk_in) begin
    if (load_en) mem <= img;
    else if (en && bus.wr_mem) mem[bus.adr_bus] <= data_bus;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  a, b, instr, m;
    logic [7:0]  exp_ac;
    logic        exp_c;
    logic [4:0]  exp_pc;
    logic [15:0] exp_cnt;
    logic [7:0]  exp_m;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    mode    = 1'b0;
    step    = 1'b0;
    load_en = 1'b1;
    cycle();
    load_en = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic pulse();
    step = 1'b1;
    en   = 1'b1;
    cycle();
    step = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_en);
    int n;
    n = 0;
    while (!idle && n < 200) begin
      en = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle();
      n++;
    end
    en = 1'b1;
    check("idle_reached", idle, 1);
  endtask

  task automatic wait_halt(input int max, output int n);
    n = 0;
    while (!halted && n < max) begin
      cycle();
      n++;
    end
  endtask

  task automatic fill_img(input logic [7:0] v);
    for (int i = 0; i < 32; i++) img[i] = v;
  endtask

  task automatic load_prog_a();
    fill_img(8'h00);
    img[0]    = 8'h50;
    img[1]    = 8'h11;
    img[2]    = 8'hC5;
    img[5]    = 8'h72;
    img[6]    = 8'hE0;
    img[5'h10] = 8'h7F;
    img[5'h11] = 8'h90;
    img[5'h12] = 8'h5A;
  endtask

  // Instruction-level reference: one call = one architectural instruction.
  task automatic model_step();
    logic [7:0] ir;
    logic [4:0] opd;
    logic [8:0] s;
    if (m_halt) return;
    ir   = mmem[m_pc];
    m_pc = m_pc + 5'd1;
    opd  = ir[4:0];
    case (ir[7:5])
      3'd0: begin
        s    = {1'b0, m_ac} + {1'b0, mmem[opd]};
        m_ac = s[7:0];
        m_c  = s[8];
      end
      3'd1: m_ac = m_ac & mmem[opd];
      3'd2: m_ac = mmem[opd];
      3'd3: mmem[opd] = m_ac;
      3'd4: m_pc = opd;
      3'd5: if (m_ac == 8'd0) m_pc = opd;
      3'd6: if (m_c) m_pc = opd;
      default: m_halt = 1'b1;
    endcase
    if (m_cnt < 65535) m_cnt++;
  endtask

  initial begin
    int n;
    int diff;

    //              a      b      instr  m      exp_ac exp_c pc     cnt     exp_m
    vecs[0]  = '{8'h10, 8'h20, 8'h10, 8'h05, 8'h35, 1'b0, 5'h04, 16'd4, 8'h05}; // ADD
    vecs[1]  = '{8'hF0, 8'h20, 8'h30, 8'h1F, 8'h10, 1'b1, 5'h04, 16'd4, 8'h1F}; // AND keeps carry
    vecs[2]  = '{8'h01, 8'h01, 8'h50, 8'hAA, 8'hAA, 1'b0, 5'h04, 16'd4, 8'hAA}; // LDA
    vecs[3]  = '{8'h80, 8'h80, 8'hC8, 8'h00, 8'h00, 1'b1, 5'h09, 16'd4, 8'h00}; // JC taken
    vecs[4]  = '{8'h7F, 8'h01, 8'hC8, 8'h00, 8'h80, 1'b0, 5'h04, 16'd4, 8'h00}; // JC not taken
    vecs[5]  = '{8'h00, 8'h00, 8'hAC, 8'h00, 8'h00, 1'b0, 5'h0D, 16'd4, 8'h00}; // JZ taken
    vecs[6]  = '{8'h01, 8'h00, 8'hAC, 8'h00, 8'h01, 1'b0, 5'h04, 16'd4, 8'h00}; // JZ not taken
    vecs[7]  = '{8'h05, 8'h06, 8'h94, 8'h00, 8'h0B, 1'b0, 5'h15, 16'd4, 8'h00}; // JMP
    vecs[8]  = '{8'h12, 8'h34, 8'h70, 8'h77, 8'h46, 1'b0, 5'h04, 16'd4, 8'h46}; // STA
    vecs[9]  = '{8'h90, 8'h10, 8'h10, 8'h70, 8'h10, 1'b1, 5'h04, 16'd4, 8'h70}; // ADD carry out
    vecs[10] = '{8'h03, 8'h04, 8'hE0, 8'h99, 8'h07, 1'b0, 5'h03, 16'd3, 8'h99}; // HLT

    // Reset state.
    load_prog_a();
    do_reset();
    check("rst_idle", idle, 1);
    check("rst_halted", halted, 0);
    check("rst_pc", pc_out, 0);
    check("rst_ac", ac_out, 0);
    check("rst_carry", carry_out, 0);
    check("rst_cnt", instr_cnt, 0);
    check("rst_rd", bus.rd_mem, 0);
    check("rst_wr", bus.wr_mem, 0);

    // Vector table: LDA a; ADD b; <instr>; HLT-filled elsewhere.
    foreach (vecs[v]) begin
      fill_img(8'hE0);
      img[0]     = 8'h5E;
      img[1]     = 8'h1D;
      img[2]     = vecs[v].instr;
      img[5'h1E] = vecs[v].a;
      img[5'h1D] = vecs[v].b;
      img[5'h10] = vecs[v].m;
      do_reset();
      mode = 1'b1;
      wait_halt(100, n);
      check($sformatf("vec%0d_halted", v), halted, 1);
      check($sformatf("vec%0d_ac", v), ac_out, vecs[v].exp_ac);
      check($sformatf("vec%0d_carry", v), carry_out, vecs[v].exp_c);
      check($sformatf("vec%0d_pc", v), pc_out, vecs[v].exp_pc);
      check($sformatf("vec%0d_cnt", v), instr_cnt, vecs[v].exp_cnt);
      check($sformatf("vec%0d_mem10", v), mem[5'h10], vecs[v].exp_m);
    end

    // Run-mode program with cycle-exact latency: 4+4+3+4+3 edges.
    load_prog_a();
    do_reset();
    mode = 1'b1;
    wait_halt(100, n);
    check("run_cycles", n, 18);
    check("run_halted", halted, 1);
    check("run_ac", ac_out, 8'h0F);
    check("run_carry", carry_out, 1);
    check("run_pc", pc_out, 7);
    check("run_cnt", instr_cnt, 5);
    check("run_mem12", mem[5'h12], 8'h0F);

    // Step mode: step held 5 cycles runs exactly one instruction.
    load_prog_a();
    do_reset();
    step = 1'b1;
    repeat (5) cycle();
    check("step_hold_ac", ac_out, 8'h7F);
    check("step_hold_idle", idle, 1);
    check("step_hold_cnt", instr_cnt, 1);
    step = 1'b0;
    cycle();
    for (int k = 1; k <= 4; k++) begin
      pulse();
      wait_idle(1'b0);
      check($sformatf("step_cnt%0d", k), instr_cnt, 1 + k);
    end
    check("step_halted", halted, 1);
    check("step_pc", pc_out, 7);
    check("step_mem12", mem[5'h12], 8'h0F);

    // Freeze for 4 cycles in EXEC_RD of the first LDA.
    load_prog_a();
    do_reset();
    mode = 1'b1;
    n = 0;
    while (!(bus.rd_mem && bus.adr_bus == 5'h10) && n < 20) begin
      cycle();
      n++;
    end
    en = 1'b0;
    repeat (4) cycle();
    check("frz_pc", pc_out, 1);
    check("frz_ac", ac_out, 0);
    check("frz_cnt", instr_cnt, 0);
    check("frz_rd", bus.rd_mem, 1);
    check("frz_adr", bus.adr_bus, 5'h10);
    check("frz_idle", idle, 0);
    en = 1'b1;
    wait_halt(100, n);
    check("frz_halted", halted, 1);
    check("frz_final_ac", ac_out, 8'h0F);
    check("frz_final_cnt", instr_cnt, 5);
    check("frz_mem12", mem[5'h12], 8'h0F);

    // Reset asserted mid EXEC_WR aborts the store.
    load_prog_a();
    do_reset();
    mode = 1'b1;
    n = 0;
    while (!bus.wr_mem && n < 50) begin
      cycle();
      n++;
    end
    check("abort_wr_seen", bus.wr_mem, 1);
    reset_n = 1'b0;
    #1;
    check("abort_wr_drop", bus.wr_mem, 0);
    check("abort_pc", pc_out, 0);
    check("abort_ac", ac_out, 0);
    check("abort_cnt", instr_cnt, 0);
    @(posedge clk_in);
    @(negedge clk_in);
    check("abort_mem12", mem[5'h12], 8'h5A);
    reset_n = 1'b1;

    // PC wrap: JMP 0x1F, then the fetch at 0x1F leaves PC at 0.
    fill_img(8'hE0);
    img[0]     = 8'h9F;
    img[5'h1F] = 8'h58;
    img[5'h18] = 8'h33;
    do_reset();
    pulse();
    wait_idle(1'b0);
    check("wrap_jmp_pc", pc_out, 5'h1F);
    pulse();
    wait_idle(1'b0);
    check("wrap_pc", pc_out, 0);
    check("wrap_ac", ac_out, 8'h33);
    pulse();
    check("wrap_fetch_rd", bus.rd_mem, 1);
    check("wrap_fetch_adr", bus.adr_bus, 0);

    // Random programs in step mode with random en stalls, vs ISA model.
    for (int p = 0; p < 15; p++) begin
      for (int i = 0; i < 32; i++) begin
        logic [2:0] op;
        op = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        img[i] = {op, 5'($urandom)};
      end
      mmem   = img;
      m_pc   = 5'd0;
      m_ac   = 8'd0;
      m_c    = 1'b0;
      m_halt = 1'b0;
      m_cnt  = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
        pulse();
        wait_idle(1'b1);
        model_step();
      end
      check($sformatf("rnd%0d_pc", p), pc_out, m_pc);
      check($sformatf("rnd%0d_ac", p), ac_out, m_ac);
      check($sformatf("rnd%0d_carry", p), carry_out, m_c);
      check($sformatf("rnd%0d_cnt", p), instr_cnt, m_cnt);
      check($sformatf("rnd%0d_halted", p), halted, m_halt);
      diff = 0;
      for (int i = 0; i < 32; i++) if (mem[i] !== mmem[i]) diff++;
      check($sformatf("rnd%0d_mem_diffs", p), diff, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
